// File: rtl/plat_seq_pkg.sv
// Types and constants shared by the frame sequencer and its testbench.
//   seq_state_e : frame sequencer FSM states
//   ERR_*       : bit positions inside o_err
//   gadget_t    : one gadget effect entry
//   EFF_*       : effect codes from define.sv
`ifndef PLAT_DEFINE_SV
`include "define.sv"
`endif

package plat_seq_pkg;

   localparam int GADGET_W = `GADGET_BIT_CNT;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_RELEASE  = 3'd2,
      ST_DISPATCH = 3'd3,
      ST_DONE     = 3'd4
   } seq_state_e;

   localparam int ERR_ACK_TIMEOUT   = 0;
   localparam int ERR_FRAME_OVERRUN = 1;

   typedef logic [GADGET_W-1:0] gadget_t;

   localparam gadget_t EFF_NONE   = `GADGET_NONE;
   localparam gadget_t EFF_EXPAND = `EXPAND;
   localparam gadget_t EFF_SHRINK = `SHRINK;
   localparam gadget_t EFF_GRAB   = `GRAB;
   localparam gadget_t EFF_SLOW   = `SLOW;
   localparam gadget_t EFF_FAST   = `FAST;

endpackage

// File: rtl/define.sv
// Shared gadget definitions for the platform game.
// GADGET_BIT_CNT : width of one gadget effect code.
// Effect codes   : values carried on the gadget effect buses.
`ifndef PLAT_DEFINE_SV
`define PLAT_DEFINE_SV

`define GADGET_BIT_CNT 3

`define GADGET_NONE 3'd0
`define EXPAND      3'd1
`define SHRINK      3'd2
`define GRAB        3'd3
`define SLOW        3'd4
`define FAST        3'd5

`endif

// File: rtl/gadget_fifo.sv
// Synchronous FIFO holding caught gadget effects until the frame
// sequencer delivers them to the platform.
//   clk, rst_n   : clock, async active-low reset
//   i_flush      : synchronous clear (wins over push/pop)
//   i_push       : write i_push_data (accepted when not full, or when popping)
//   i_pop        : drop the head entry (ignored when empty)
//   o_head       : current head entry
//   o_full/o_empty/o_count : occupancy
module gadget_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 3,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop, full, empty;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A pop frees the head slot in the same cycle, so a full FIFO can
   // still accept a push alongside it.
   assign do_pop  = i_pop && !empty && !i_flush;
   assign do_push = i_push && (!full || do_pop) && !i_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count says valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_push_data;
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_full  = full;
   assign o_empty = empty;
   assign o_count = count_q;

endmodule

// File: rtl/plat_frame_sequencer.sv
// Per-frame controller for the platform block. On each frame strobe it
// runs the position-update req/ack handshake with the platform, then
// hands up to MAX_PER_FRAME buffered gadget effects to the platform, one
// per cycle. Caught gadgets from NUM_SRC slots are round-robin
// arbitrated into a FIFO so the platform gadget input has one source.
//   clk, rst_n             : clock, async active-low reset
//   i_game_start           : synchronous flush of all sequencer state
//   i_cal_frame            : one-cycle frame strobe
//   i_gadget_valid/effect  : per-slot caught gadget, effect n at [n*W +: W]
//   o_gadget_ready         : one-hot accept pulse back to the slot
//   o_plat_req, i_plat_ack : position-update handshake
//   o_plat_gadget_effect   : effect delivered to the platform (held)
//   o_plat_receive_gadget  : one-cycle strobe with each delivery
//   o_frame_done           : one-cycle pulse at end of frame sequence
//   o_err                  : sticky, [0] ack timeout, [1] frame overrun
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_cal_frame
// REQ      | o_plat_req high, waiting for ack or timeout
// RELEASE  | req dropped for one cycle so the platform clears ack
// DISPATCH | popping FIFO entries to the platform, one per cycle
// DONE     | o_frame_done high for one cycle
module plat_frame_sequencer
   import plat_seq_pkg::*;
#(
   parameter int NUM_SRC       = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_PER_FRAME = 2,
   parameter int ACK_TIMEOUT   = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_game_start,
   input  logic                         i_cal_frame,
   input  logic [NUM_SRC-1:0]           i_gadget_valid,
   input  logic [NUM_SRC*GADGET_W-1:0]  i_gadget_effect,
   output logic [NUM_SRC-1:0]           o_gadget_ready,
   output logic                         o_plat_req,
   input  logic                         i_plat_ack,
   output logic [GADGET_W-1:0]          o_plat_gadget_effect,
   output logic                         o_plat_receive_gadget,
   output logic                         o_frame_done,
   output logic [1:0]                   o_err
);

   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   localparam int DLV_W = $clog2(MAX_PER_FRAME + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   seq_state_e         state_q, state_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [DLV_W-1:0]   dlv_cnt_q, dlv_cnt_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               plat_req_q, plat_req_d;
   gadget_t            plat_eff_q, plat_eff_d;
   logic               plat_rx_q, plat_rx_d;
   logic [NUM_SRC-1:0] ready_q, ready_d;
   logic               frame_done_q, frame_done_d;
   logic [1:0]         err_q, err_d;

   gadget_t            slot_eff [NUM_SRC];
   logic               grant_vld;
   logic [SRC_W-1:0]   grant_idx;
   logic               push, pop;
   gadget_t            fifo_head;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   unused_fifo_count;

   for (genvar n = 0; n < NUM_SRC; n++) begin : g_slot
      assign slot_eff[n] = i_gadget_effect[n*GADGET_W +: GADGET_W];
   end

   // First valid slot at or after the pointer, wrapping. A slot whose
   // ready pulse is out this cycle still shows valid, so it is skipped.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin : scan
         logic [SRC_W-1:0] cand;
         cand = SRC_W'((int'(rr_ptr_q) + i) % NUM_SRC);
         if (!grant_vld && i_gadget_valid[cand] && !ready_q[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign pop  = (state_q == ST_DISPATCH) && !fifo_empty &&
                 (dlv_cnt_q < DLV_W'(MAX_PER_FRAME)) && !i_game_start;
   assign push = grant_vld && (!fifo_full || pop) && !i_game_start;

   gadget_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (GADGET_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (i_game_start),
      .i_push      (push),
      .i_push_data (slot_eff[grant_idx]),
      .i_pop       (pop),
      .o_head      (fifo_head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_count     (unused_fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      tmo_cnt_d    = tmo_cnt_q;
      dlv_cnt_d    = dlv_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      plat_req_d   = plat_req_q;
      plat_eff_d   = plat_eff_q;
      plat_rx_d    = 1'b0;
      ready_d      = '0;
      frame_done_d = 1'b0;
      err_d        = err_q;

      if (push) begin
         ready_d[grant_idx] = 1'b1;
         rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0
                                                       : grant_idx + SRC_W'(1);
      end

      if (pop) begin
         plat_eff_d = fifo_head;
         plat_rx_d  = 1'b1;
      end

      if (i_cal_frame && (state_q != ST_IDLE)) err_d[ERR_FRAME_OVERRUN] = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (i_cal_frame) begin
               state_d    = ST_REQ;
               plat_req_d = 1'b1;
               tmo_cnt_d  = TMO_W'(ACK_TIMEOUT - 1);
               dlv_cnt_d  = '0;
            end
         end
         ST_REQ: begin
            // Ack takes precedence over a timeout landing in the same cycle.
            if (i_plat_ack) begin
               state_d    = ST_RELEASE;
               plat_req_d = 1'b0;
            end else if (tmo_cnt_q == '0) begin
               state_d    = ST_DISPATCH;
               plat_req_d = 1'b0;
               err_d[ERR_ACK_TIMEOUT] = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
            end
         end
         ST_RELEASE: begin
            state_d = ST_DISPATCH;
         end
         ST_DISPATCH: begin
            if (pop) begin
               dlv_cnt_d = dlv_cnt_q + DLV_W'(1);
            end else begin
               state_d      = ST_DONE;
               frame_done_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Game start mirrors the platform clearing its own effect registers,
      // so nothing queued before it may reach the platform afterwards.
      if (i_game_start) begin
         state_d      = ST_IDLE;
         rr_ptr_d     = '0;
         plat_req_d   = 1'b0;
         plat_eff_d   = '0;
         plat_rx_d    = 1'b0;
         ready_d      = '0;
         frame_done_d = 1'b0;
         err_d        = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tmo_cnt_q    <= '0;
         dlv_cnt_q    <= '0;
         rr_ptr_q     <= '0;
         plat_req_q   <= 1'b0;
         plat_eff_q   <= '0;
         plat_rx_q    <= 1'b0;
         ready_q      <= '0;
         frame_done_q <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         tmo_cnt_q    <= tmo_cnt_d;
         dlv_cnt_q    <= dlv_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         plat_req_q   <= plat_req_d;
         plat_eff_q   <= plat_eff_d;
         plat_rx_q    <= plat_rx_d;
         ready_q      <= ready_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign o_gadget_ready        = ready_q;
   assign o_plat_req            = plat_req_q;
   assign o_plat_gadget_effect  = plat_eff_q;
   assign o_plat_receive_gadget = plat_rx_q;
   assign o_frame_done          = frame_done_q;
   assign o_err                 = err_q;

endmodule

// File: tb/tb_plat_frame_sequencer.sv
// Directed testbench for plat_frame_sequencer with a small platform
// model (req/ack responder, position counter, delivery log).
module tb_plat_frame_sequencer;
   import plat_seq_pkg::*;

   localparam int NSRC = 4;
   localparam int W    = GADGET_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_game_start = 1'b0;
   logic              i_cal_frame = 1'b0;
   logic [NSRC-1:0]   i_gadget_valid = '0;
   logic [NSRC*W-1:0] i_gadget_effect = '0;
   logic [NSRC-1:0]   o_gadget_ready;
   logic              o_plat_req;
   logic              i_plat_ack;
   logic [W-1:0]      o_plat_gadget_effect;
   logic              o_plat_receive_gadget;
   logic              o_frame_done;
   logic [1:0]        o_err;

   plat_frame_sequencer dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .i_game_start          (i_game_start),
      .i_cal_frame           (i_cal_frame),
      .i_gadget_valid        (i_gadget_valid),
      .i_gadget_effect       (i_gadget_effect),
      .o_gadget_ready        (o_gadget_ready),
      .o_plat_req            (o_plat_req),
      .i_plat_ack            (i_plat_ack),
      .o_plat_gadget_effect  (o_plat_gadget_effect),
      .o_plat_receive_gadget (o_plat_receive_gadget),
      .o_frame_done          (o_frame_done),
      .o_err                 (o_err)
   );

   always #5 clk = ~clk;

   // platform: acks one cycle after seeing req, clears ack when it sees
   // req and ack together
   logic ack_en = 1'b1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     i_plat_ack <= 1'b0;
      else if (!ack_en)               i_plat_ack <= 1'b0;
      else if (o_plat_req && !i_plat_ack) i_plat_ack <= 1'b1;
      else if (o_plat_req && i_plat_ack)  i_plat_ack <= 1'b0;
   end

   logic   mon_clr = 1'b1;
   int     cyc = 0;
   int     req_cyc, pos_cnt, rx_n, grant_n;
   logic [W-1:0] rx_eff [8];
   int     rx_at [8];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         req_cyc <= 0;
         pos_cnt <= 0;
         rx_n    <= 0;
         grant_n <= 0;
      end else begin
         if (o_plat_req) req_cyc <= req_cyc + 1;
         if (o_plat_req && i_plat_ack) pos_cnt <= pos_cnt + 1;
         if (o_plat_receive_gadget && rx_n < 8) begin
            rx_eff[rx_n] <= o_plat_gadget_effect;
            rx_at[rx_n]  <= cyc;
            rx_n         <= rx_n + 1;
         end
         grant_n <= grant_n + $countones(o_gadget_ready);
      end
   end

   int n_chk = 0;
   int n_bad = 0;
   logic auto_drop = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one cycle; slots that just saw their ready pulse drop valid
   task automatic tick();
      @(negedge clk);
      if (auto_drop) i_gadget_valid = i_gadget_valid & ~o_gadget_ready;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   task automatic set_eff(input int slot, input logic [W-1:0] code);
      i_gadget_effect[slot*W +: W] = code;
   endtask

   // strobe a frame; lat = edges from the strobe edge to frame_done, -1 if none
   task automatic run_frame(output int lat);
      i_cal_frame = 1'b1;
      tick();
      i_cal_frame = 1'b0;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (o_frame_done) begin
            lat = i;
            break;
         end
         tick();
      end
   endtask

   int lat;

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      mon_clr = 1'b0;

      // reset state
      chk("rst_req",   int'(o_plat_req), 0);
      chk("rst_rx",    int'(o_plat_receive_gadget), 0);
      chk("rst_eff",   int'(o_plat_gadget_effect), 0);
      chk("rst_ready", int'(o_gadget_ready), 0);
      chk("rst_done",  int'(o_frame_done), 0);
      chk("rst_err",   int'(o_err), 0);

      // plain frame with prompt ack
      clear_mon();
      run_frame(lat);
      chk("f1_lat", lat, 4);
      tick();
      chk("f1_done_pulse", int'(o_frame_done), 0);
      chk("f1_req_cyc", req_cyc, 2);
      chk("f1_pos", pos_cnt, 1);
      chk("f1_err", int'(o_err), 0);
      chk("f1_rx_n", rx_n, 0);

      // slots 1 and 3 together, pointer at 0
      set_eff(1, EFF_EXPAND);
      set_eff(3, EFF_GRAB);
      auto_drop = 1'b1;
      i_gadget_valid = 4'b1010;
      tick();
      chk("rr_first", int'(o_gadget_ready), 2);
      tick();
      chk("rr_second", int'(o_gadget_ready), 8);
      tick();
      chk("rr_idle", int'(o_gadget_ready), 0);
      clear_mon();
      run_frame(lat);
      chk("f2_lat", lat, 6);
      chk("f2_rx_n", rx_n, 2);
      chk("f2_rx0", int'(rx_eff[0]), int'(EFF_EXPAND));
      chk("f2_rx1", int'(rx_eff[1]), int'(EFF_GRAB));
      chk("f2_consec", rx_at[1] - rx_at[0], 1);
      chk("f2_eff_held", int'(o_plat_gadget_effect), int'(EFF_GRAB));

      // all slots valid continuously: fills FIFO, then stalls
      auto_drop = 1'b0;
      set_eff(0, EFF_SHRINK);
      set_eff(1, EFF_SLOW);
      set_eff(2, EFF_FAST);
      set_eff(3, EFF_EXPAND);
      clear_mon();
      i_gadget_valid = 4'b1111;
      tick();
      chk("fill_first", int'(o_gadget_ready), 1);
      repeat (7) tick();
      chk("fill_grants", grant_n, 4);
      chk("fill_stall", int'(o_gadget_ready), 0);
      clear_mon();
      run_frame(lat);
      repeat (3) tick();
      chk("f3_lat", lat, 6);
      chk("f3_grants", grant_n, 2);
      chk("f3_rx_n", rx_n, 2);
      chk("f3_rx0", int'(rx_eff[0]), int'(EFF_SHRINK));
      chk("f3_rx1", int'(rx_eff[1]), int'(EFF_SLOW));
      i_gadget_valid = '0;

      // platform never acks; FIFO holds FAST, EXPAND, SHRINK, SLOW
      ack_en = 1'b0;
      clear_mon();
      run_frame(lat);
      chk("tmo_lat", lat, 18);
      chk("tmo_req_cyc", req_cyc, 15);
      chk("tmo_err", int'(o_err), 1);
      chk("tmo_pos", pos_cnt, 0);
      chk("tmo_rx_n", rx_n, 2);
      chk("tmo_rx0", int'(rx_eff[0]), int'(EFF_FAST));
      chk("tmo_rx1", int'(rx_eff[1]), int'(EFF_EXPAND));
      ack_en = 1'b1;

      // FIFO: SHRINK, SLOW + GRAB
      auto_drop = 1'b1;
      set_eff(2, EFF_GRAB);
      i_gadget_valid = 4'b0100;
      repeat (2) tick();

      // strobe again while in DISPATCH
      clear_mon();
      i_cal_frame = 1'b1;
      tick();
      i_cal_frame = 1'b0;
      repeat (3) tick();
      i_cal_frame = 1'b1;
      tick();
      i_cal_frame = 1'b0;
      chk("ovr_err", int'(o_err), 3);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         if (o_frame_done) begin
            lat = i;
            break;
         end
         tick();
      end
      chk("ovr_done_seen", int'(lat >= 0), 1);
      repeat (4) tick();
      chk("ovr_no_new_req", req_cyc, 2);
      chk("ovr_rx_n", rx_n, 2);

      // FIFO: GRAB + FAST, EXPAND -> 3 entries, then game start
      set_eff(0, EFF_FAST);
      set_eff(1, EFF_EXPAND);
      i_gadget_valid = 4'b0011;
      repeat (3) tick();
      set_eff(2, EFF_SHRINK);
      i_gadget_valid = 4'b0100;
      i_game_start = 1'b1;
      i_cal_frame = 1'b1;
      tick();
      i_game_start = 1'b0;
      i_cal_frame = 1'b0;
      i_gadget_valid = '0;
      chk("gs_err", int'(o_err), 0);
      chk("gs_req", int'(o_plat_req), 0);
      chk("gs_rx", int'(o_plat_receive_gadget), 0);
      chk("gs_no_grant", int'(o_gadget_ready), 0);
      chk("gs_eff", int'(o_plat_gadget_effect), 0);
      clear_mon();
      run_frame(lat);
      chk("gs_frame_lat", lat, 4);
      chk("gs_rx_n", rx_n, 0);
      chk("gs_req_cyc", req_cyc, 2);

      // async reset in the middle of REQ
      tick();
      i_cal_frame = 1'b1;
      tick();
      i_cal_frame = 1'b0;
      tick();
      chk("rst_mid_req_hi", int'(o_plat_req), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req_lo", int'(o_plat_req), 0);
      chk("rst_mid_err", int'(o_err), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      clear_mon();
      run_frame(lat);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_req_cyc", req_cyc, 2);
      chk("post_rst_pos", pos_cnt, 1);
      chk("post_rst_err", int'(o_err), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
